// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults, FSM and phase types, phase decode helper
package vga_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;

    function automatic phase_t phase_of(input int c, input int act, input int fp, input int sy);
        return c < act ? ACT : c < act + fp ? FP : c < act + fp + sy ? SYNC : BP;
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis counter with wrap flag and phase decode
// Ports: clock, reset (async, active-high), inc (advance by one);
//        nxt (count value after this edge), phase (phase of nxt), wrap (count at TOTAL-1)
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE   = H_ACTIVE_DEF,
    parameter int FRONT    = H_FRONT_DEF,
    parameter int SYNC_LEN = H_SYNC_DEF,
    parameter int BACK     = H_BACK_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    output logic [9:0] nxt,
    output phase_t     phase,
    output logic       wrap
);
    localparam int TOTAL = ACTIVE + FRONT + SYNC_LEN + BACK;

    if (TOTAL > 1024) begin : g_bad_total
        $error("vga_axis_counter: total %0d does not fit a 10-bit counter", TOTAL);
    end

    logic [9:0] count;

    assign wrap  = count == 10'(TOTAL - 1);
    assign nxt   = !inc ? count : wrap ? '0 : count + 10'd1;
    // Phase is decoded from the upcoming count so the top can register it in step with the counter.
    assign phase = phase_of(int'(nxt), ACTIVE, FRONT, SYNC_LEN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) count <= '0;
        else       count <= nxt;
    end
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA timing sequencer with run/stop control on frame boundaries
// Ports: clock, reset (async, active-high), enable (run request);
//        hsync/vsync (asserted == SYNC_POL), active, xpos/ypos (0 outside visible area),
//        line_start/frame_start strobes, frame_count (completed frames), running (RUN or DRAIN)
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int FRAME_W  = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [9:0]         xpos,
    output logic [9:0]         ypos,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count,
    output logic               running
);
    state_t     st, st_n;
    logic       run, run_n, act_n, h_wrap, v_wrap, frame_end;
    logic [9:0] h_nxt, v_nxt;
    phase_t     h_ph, v_ph;

    assign run       = st != IDLE;
    assign frame_end = h_wrap && v_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC_LEN(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .clock(clock), .reset(reset), .inc(run), .nxt(h_nxt), .phase(h_ph), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC_LEN(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .clock(clock), .reset(reset), .inc(run && h_wrap), .nxt(v_nxt), .phase(v_ph), .wrap(v_wrap)
    );

    // Counters only move while running, so leaving IDLE shows position (0,0) on the first RUN cycle.
    always_comb begin
        st_n  = st;
        run_n = 1'b0;
        act_n = 1'b0;
        st_n  = st == IDLE ? (enable ? RUN : IDLE)
              : enable ? RUN
              : (st == DRAIN && frame_end) ? IDLE : DRAIN;
        run_n = st_n != IDLE;
        act_n = run_n && h_ph == ACT && v_ph == ACT;
    end

    // Every output is registered from the same upcoming (hcnt, vcnt), keeping them mutually aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st          <= IDLE;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            active      <= 1'b0;
            xpos        <= '0;
            ypos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            running     <= 1'b0;
        end else begin
            st          <= st_n;
            hsync       <= (run_n && h_ph == SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (run_n && v_ph == SYNC) ? SYNC_POL : ~SYNC_POL;
            active      <= act_n;
            xpos        <= act_n ? h_nxt : '0;
            ypos        <= act_n ? v_nxt : '0;
            line_start  <= run_n && h_nxt == '0;
            frame_start <= run_n && h_nxt == '0 && v_nxt == '0;
            frame_count <= frame_count + FRAME_W'(run && frame_end);
            running     <= run_n;
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: default and small-geometry instances checked against a linear-position frame model
module tb_vga_timing_ctrl;
    typedef struct packed {bit run; bit drain; int p; int fc;} mstate_t;
    typedef struct packed {bit hs; bit vs; bit act; int x; int y; bit ls; bit fs; int fc; bit run;} out_t;

    localparam int HA [2] = '{640, 4};
    localparam int HF [2] = '{16, 1};
    localparam int HS [2] = '{96, 2};
    localparam int HB [2] = '{48, 1};
    localparam int VA [2] = '{480, 3};
    localparam int VF [2] = '{10, 1};
    localparam int VS [2] = '{2, 1};
    localparam int VB [2] = '{33, 1};
    localparam bit POL [2] = '{1'b0, 1'b1};
    localparam int FW [2] = '{10, 2};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic d_en = 1'b0, s_en = 1'b0;
    logic d_hsync, d_vsync, d_active, d_ls, d_fs, d_running;
    logic [9:0] d_xpos, d_ypos, d_fc;
    logic s_hsync, s_vsync, s_active, s_ls, s_fs, s_running;
    logic [9:0] s_xpos, s_ypos;
    logic [1:0] s_fc;

    int n_chk = 0, n_fail = 0;
    bit chk_on = 1'b0;
    mstate_t m0 = '0, m1 = '0;

    always #5 clock = ~clock;

    vga_timing_ctrl u_d (
        .clock(clock), .reset(reset), .enable(d_en), .hsync(d_hsync), .vsync(d_vsync),
        .active(d_active), .xpos(d_xpos), .ypos(d_ypos), .line_start(d_ls),
        .frame_start(d_fs), .frame_count(d_fc), .running(d_running)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1), .FRAME_W(2)
    ) u_s (
        .clock(clock), .reset(reset), .enable(s_en), .hsync(s_hsync), .vsync(s_vsync),
        .active(s_active), .xpos(s_xpos), .ypos(s_ypos), .line_start(s_ls),
        .frame_start(s_fs), .frame_count(s_fc), .running(s_running)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ht(input int k);
        return HA[k] + HF[k] + HS[k] + HB[k];
    endfunction

    function automatic int vt(input int k);
        return VA[k] + VF[k] + VS[k] + VB[k];
    endfunction

    // Model: position is a single index p into the frame; display stops only when a
    // drain reaches the last pixel of a frame with enable still low.
    function automatic mstate_t step(input mstate_t s, input bit en, input int k);
        mstate_t n;
        int ft;
        bit fe;
        n  = s;
        ft = ht(k) * vt(k);
        fe = s.p == ft - 1;
        if (!s.run) begin
            n.run   = en;
            n.drain = 1'b0;
        end else begin
            n.p = (s.p + 1) % ft;
            if (fe) n.fc = (s.fc + 1) % (1 << FW[k]);
            if (s.drain && fe && !en) begin
                n.run   = 1'b0;
                n.drain = 1'b0;
            end else begin
                n.drain = !en;
            end
        end
        return n;
    endfunction

    function automatic out_t model_out(input mstate_t s, input int k);
        out_t o;
        int h, v;
        bit hin, vin;
        h   = s.p % ht(k);
        v   = s.p / ht(k);
        hin = h >= HA[k] + HF[k] && h < HA[k] + HF[k] + HS[k];
        vin = v >= VA[k] + VF[k] && v < VA[k] + VF[k] + VS[k];
        o.hs  = (s.run && hin) ? POL[k] : !POL[k];
        o.vs  = (s.run && vin) ? POL[k] : !POL[k];
        o.act = s.run && h < HA[k] && v < VA[k];
        o.x   = o.act ? h : 0;
        o.y   = o.act ? v : 0;
        o.ls  = s.run && h == 0;
        o.fs  = s.run && s.p == 0;
        o.fc  = s.fc;
        o.run = s.run;
        return o;
    endfunction

    task automatic cmp(input int k, input out_t g, input mstate_t m);
        out_t e;
        string pre;
        e   = model_out(m, k);
        pre = k == 0 ? "d." : "s.";
        chk({pre, "hsync"}, int'(g.hs), int'(e.hs));
        chk({pre, "vsync"}, int'(g.vs), int'(e.vs));
        chk({pre, "active"}, int'(g.act), int'(e.act));
        chk({pre, "xpos"}, g.x, e.x);
        chk({pre, "ypos"}, g.y, e.y);
        chk({pre, "line_start"}, int'(g.ls), int'(e.ls));
        chk({pre, "frame_start"}, int'(g.fs), int'(e.fs));
        chk({pre, "frame_count"}, g.fc, e.fc);
        chk({pre, "running"}, int'(g.run), int'(e.run));
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= step(m0, d_en, 0);
            m1 <= step(m1, s_en, 1);
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            cmp(0, '{d_hsync, d_vsync, d_active, int'(d_xpos), int'(d_ypos), d_ls, d_fs, int'(d_fc), d_running}, m0);
            cmp(1, '{s_hsync, s_vsync, s_active, int'(s_xpos), int'(s_ypos), s_ls, s_fs, int'(s_fc), s_running}, m1);
        end
    end

    initial begin
        int ls0, ls1, hs_fall, hs_rise, vs_low, waited;
        bit prev_hs;
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        chk_on = 1'b1;
        repeat (100) @(negedge clock);
        chk("idle.hsync", int'(d_hsync), 1);
        chk("idle.vsync", int'(d_vsync), 1);
        chk("idle.running", int'(d_running), 0);
        chk("idle.frame_count", int'(d_fc), 0);

        d_en = 1'b1;
        @(negedge clock);
        chk("first.frame_start", int'(d_fs), 1);
        chk("first.line_start", int'(d_ls), 1);
        chk("first.active", int'(d_active), 1);
        chk("first.xpos", int'(d_xpos), 0);
        chk("first.ypos", int'(d_ypos), 0);
        ls0 = 0; ls1 = -1; hs_fall = -1; hs_rise = -1; vs_low = 0;
        prev_hs = d_hsync;
        for (int c = 1; c < 1700; c++) begin
            @(negedge clock);
            if (d_ls && ls1 < 0) ls1 = c;
            if (prev_hs && !d_hsync && hs_fall < 0) hs_fall = c;
            if (!prev_hs && d_hsync && hs_rise < 0) hs_rise = c;
            if (!d_vsync) vs_low++;
            prev_hs = d_hsync;
        end
        chk("hsync.start", hs_fall - ls0, 656);
        chk("hsync.width", hs_rise - hs_fall, 96);
        chk("line.period", ls1 - ls0, 800);
        chk("vsync.early_lines", vs_low, 0);

        waited = 0;
        while (d_hsync && waited < 900) begin
            @(negedge clock);
            waited++;
        end
        chk("wait.hsync_low", int'(d_hsync), 0);
        #2 reset = 1'b1;
        #1;
        chk("async.hsync", int'(d_hsync), 1);
        chk("async.active", int'(d_active), 0);
        chk("async.xpos", int'(d_xpos), 0);
        chk("async.line_start", int'(d_ls), 0);
        chk("async.running", int'(d_running), 0);
        chk("async.frame_count", int'(d_fc), 0);
        d_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);

        s_en = 1'b1;
        @(negedge clock);
        chk("s.first.frame_start", int'(s_fs), 1);
        chk("s.first.active", int'(s_active), 1);
        for (int c = 1; c <= 192; c++) begin
            @(negedge clock);
            if (c == 3)   chk("s.c3.xpos", int'(s_xpos), 3);
            if (c == 4)   chk("s.c4.active", int'(s_active), 0);
            if (c == 4)   chk("s.c4.hsync", int'(s_hsync), 0);
            if (c == 5)   chk("s.c5.hsync", int'(s_hsync), 1);
            if (c == 6)   chk("s.c6.hsync", int'(s_hsync), 1);
            if (c == 7)   chk("s.c7.hsync", int'(s_hsync), 0);
            if (c == 16)  chk("s.c16.ypos", int'(s_ypos), 2);
            if (c == 24)  chk("s.c24.active", int'(s_active), 0);
            if (c == 31)  chk("s.c31.vsync", int'(s_vsync), 0);
            if (c == 32)  chk("s.c32.vsync", int'(s_vsync), 1);
            if (c == 39)  chk("s.c39.vsync", int'(s_vsync), 1);
            if (c == 40)  chk("s.c40.vsync", int'(s_vsync), 0);
            if (c == 48)  chk("s.c48.frame_start", int'(s_fs), 1);
            if (c == 48)  chk("s.c48.frame_count", int'(s_fc), 1);
            if (c == 143) chk("s.c143.frame_count", int'(s_fc), 2);
            if (c == 144) chk("s.c144.frame_count", int'(s_fc), 3);
            if (c == 192) chk("s.c192.frame_count", int'(s_fc), 0);
            if (c == 192) chk("s.c192.frame_start", int'(s_fs), 1);
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if ($urandom_range(15) == 0) s_en = ~s_en;
            if ($urandom_range(63) == 0) d_en = ~d_en;
            if ($urandom_range(1499) == 0) begin
                #2 reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
        end
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
